// File: rtl/interrupt_controller.sv
// Interrupt controller: IF/IE/IME registers, fixed-priority source selection
// and the request/acknowledge handshake with the control sequencer.
module interrupt_controller #(
    parameter int unsigned NUM_SRC  = 5,
    parameter logic [15:0] VEC_BASE = 16'h0040
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [15:0]        bus_addr,
    input  logic               bus_wr,
    input  logic               bus_rd,
    input  logic [7:0]         bus_wdata,
    output logic [7:0]         bus_rdata,
    output logic               bus_sel,
    input  logic               ei,
    input  logic               di,
    input  logic               reti,
    input  logic               instr_done,
    input  logic               int_ack,
    input  logic               dispatch_done,
    output logic               int_req,
    output logic [15:0]        int_vector,
    output logic               wake,
    output logic               ime_out,
    output logic [NUM_SRC-1:0] if_out,
    output logic [7:0]         ie_out
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_nxt;
    logic [NUM_SRC-1:0] if_reg, if_nxt;
    logic [7:0]         ie_reg, ie_nxt;
    logic               ime, ime_nxt;
    logic               ei_pending, ei_pending_nxt;
    logic [15:0]        vec_reg, vec_nxt;

    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] clr_mask;
    logic [15:0]        vec_sel;
    logic               found;
    logic               ack;
    logic               sel_if, sel_ie;
    logic [7:0]         rd_if;

    assign sel_if  = (bus_addr == 16'hFF0F);
    assign sel_ie  = (bus_addr == 16'hFFFF);
    assign bus_sel = sel_if | sel_ie;

    assign pend    = if_reg & ie_reg[NUM_SRC-1:0];
    assign wake    = |pend;
    assign int_req = ime & (|pend) & (state == IDLE);
    assign ack     = int_ack & (state == IDLE);

    // Lowest pending index wins; an empty pend yields a zero vector and no clear.
    always_comb begin
        found    = 1'b0;
        clr_mask = '0;
        vec_sel  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (pend[i] && !found) begin
                found       = 1'b1;
                clr_mask[i] = 1'b1;
                vec_sel     = VEC_BASE + 16'(i << 3);
            end
        end
    end

    always_comb begin
        rd_if = '1;
        rd_if[NUM_SRC-1:0] = if_reg;
        bus_rdata = '0;
        if (bus_rd && sel_if)
            bus_rdata = rd_if;
        else if (bus_rd && sel_ie)
            bus_rdata = ie_reg;
    end

    always_comb begin
        state_nxt      = state;
        if_nxt         = if_reg;
        ie_nxt         = ie_reg;
        ime_nxt        = ime;
        ei_pending_nxt = ei_pending;
        vec_nxt        = vec_reg;

        if (bus_wr && sel_if)
            if_nxt = bus_wdata[NUM_SRC-1:0];
        if (bus_wr && sel_ie)
            ie_nxt = bus_wdata;
        if (ack)
            if_nxt = if_nxt & ~clr_mask;
        if_nxt = if_nxt | irq_in;

        // Lowest priority first so that reti, di and acknowledge override in turn.
        if (ei_pending && instr_done && !ei) begin
            ime_nxt        = 1'b1;
            ei_pending_nxt = 1'b0;
        end
        if (ei)
            ei_pending_nxt = 1'b1;
        if (reti) begin
            ime_nxt        = 1'b1;
            ei_pending_nxt = 1'b0;
        end
        if (di || ack) begin
            ime_nxt        = 1'b0;
            ei_pending_nxt = 1'b0;
        end

        case (state)
            IDLE: if (int_ack) begin
                state_nxt = BUSY;
                vec_nxt   = found ? vec_sel : 16'h0000;
            end
            BUSY: if (dispatch_done)
                state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            if_reg     <= '0;
            ie_reg     <= '0;
            ime        <= 1'b0;
            ei_pending <= 1'b0;
            vec_reg    <= '0;
        end else begin
            state      <= state_nxt;
            if_reg     <= if_nxt;
            ie_reg     <= ie_nxt;
            ime        <= ime_nxt;
            ei_pending <= ei_pending_nxt;
            vec_reg    <= vec_nxt;
        end
    end

    assign int_vector = vec_reg;
    assign ime_out    = ime;
    assign if_out     = if_reg;
    assign ie_out     = ie_reg;

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Holds the IF (0xFF0F) and IE (0xFFFF) registers and the IME master enable, and prioritises the five interrupt sources.
- Raises a request to the control sequencer at instruction boundaries.
- On acknowledge, supplies the 16-bit vector that the sequencer loads into PC through the register file's 16-bit write path (write_rr / PC).
- Sits between the peripherals and memory bus on one side and the CPU control unit / register file on the other.

Parameters:
NUM_SRC, 5, number of interrupt sources (bit 0 = VBlank ... bit 4 = Joypad; bit 0 has highest priority)
VEC_BASE, 16'h0040, vector of source 0; source n vectors to VEC_BASE + 8*n

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
irq_in  in  NUM_SRC  request pulses from peripherals; a 1 sets the matching IF bit
bus_addr  in  16  CPU bus address
bus_wr  in  1  bus write strobe
bus_rd  in  1  bus read strobe
bus_wdata  in  8  bus write data
bus_rdata  out  8  read data; 8'h00 when not selected
bus_sel  out  1  combinational, high when bus_addr is 0xFF0F or 0xFFFF
ei  in  1  EI executed (1-cycle pulse)
di  in  1  DI executed (1-cycle pulse)
reti  in  1  RETI executed (1-cycle pulse)
instr_done  in  1  instruction-boundary pulse from the sequencer
int_ack  in  1  sequencer begins dispatch (1-cycle pulse)
dispatch_done  in  1  sequencer has loaded PC (1-cycle pulse)
int_req  out  1  dispatch request
int_vector  out  16  vector latched at acknowledge
wake  out  1  HALT exit condition
ime_out  out  1  current IME
if_out  out  NUM_SRC  IF contents
ie_out  out  8  IE contents

Behaviour:
- Reset values: IF=0, IE=0, IME=0, ei_pending=0, state=IDLE, int_vector=16'h0000. All outputs therefore reset to 0.
- pend = IF & IE[NUM_SRC-1:0]. wake = |pend, independent of IME and state (combinational).
- int_req = IME & |pend & (state==IDLE) (combinational).
- Bus reads are combinational:
  - 0xFF0F returns {3'b111, IF}.
  - 0xFFFF returns IE (all 8 bits stored).
  - Other addresses, or bus_rd low, return 8'h00.
- IF update order within one cycle, later steps win:
  1. Bus write to 0xFF0F loads bus_wdata[4:0].
  2. Acknowledge clears the latched source bit.
  3. irq_in bits are ORed in.
  A request arriving in the same cycle as its own clear or a bus write of 0 is therefore kept.
- IE bus write takes effect on the next edge.
- IME:
  - di clears IME and ei_pending on the next edge.
  - reti sets IME on the next edge and clears ei_pending.
  - ei sets ei_pending. IME becomes 1 on the edge of the first instr_done that arrives strictly after the ei cycle; ei_pending then clears.
  - ei and instr_done in the same cycle does not enable IME yet.
  - di in the same cycle as ei or reti: di wins.
  - Acknowledge clears IME and ei_pending; this has priority over all of the above.
- State machine, IDLE -> BUSY -> IDLE:
  - IDLE: int_ack moves to BUSY. On that edge:
    - idx = lowest set bit of pend.
    - int_vector <= VEC_BASE + 8*idx.
    - IF[idx] is cleared and IME is cleared.
    - If pend==0 at acknowledge (IE or IF cleared after the request was seen), int_vector <= 16'h0000, no IF bit is cleared, and IME is still cleared.
  - BUSY: int_req is 0. int_ack is ignored. IF, IE and irq_in keep updating. dispatch_done returns to IDLE on the next edge.
  - int_vector holds its value until the next acknowledge.
- int_ack while IME=0 or int_req=0 is still honoured as above; the sequencer guarantees legality.
- Reset in any state returns to IDLE with reset values on the next edge. A dispatch in progress is abandoned.
- Latency: an irq_in pulse produces int_req one cycle later (IF registered), provided IE and IME are set.

Test Plan:
- Priority: IE=0x1F, IME=1, irq_in=5'b10100 -> int_req=1 next cycle. int_ack -> int_vector=16'h0050, IF=5'b10000, IME=0. dispatch_done, then reti -> int_req=1; next ack -> int_vector=16'h0060.
- EI delay: IME=0, IF=0x01, IE=0x01. Pulse ei together with instr_done -> IME stays 0. Next instr_done -> IME=1, int_req=1.
- Cancel race: int_req high for IF bit 1. Bus write IE=0x00 in the cycle before int_ack -> int_vector=16'h0000, IF still 0x02, IME=0.
- Bus readback: write 0xFF0F=0xFF -> read returns 0xFF and if_out=5'h1F. Write 0xFF0F=0x00 with irq_in=5'b00001 in the same cycle -> IF=0x01, read 0xE1. Read 0x1234 -> 0x00, bus_sel=0.
- HALT wake: IME=0, IE=0x04, irq_in bit 2 -> wake=1 next cycle, int_req=0.
- Reset mid-dispatch: reset while BUSY -> state IDLE, IF=IE=0, IME=0, int_vector=0, int_req=0. A subsequent dispatch_done has no effect.
